// File: rtl/parity_pkg.sv
// Shared types and the parity function used by both the TX generator and the RX checker.
package parity_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    PAR  = 2'b10
  } chk_state_t;

  // xor_in is the XOR-reduction of the data bits; mark/space ignore it.
  function automatic logic par_fn(input par_mode_t mode, input logic xor_in);
    logic bit_out;
    case (mode)
      PAR_EVEN:  bit_out = xor_in;
      PAR_ODD:   bit_out = ~xor_in;
      PAR_MARK:  bit_out = 1'b1;
      PAR_SPACE: bit_out = 1'b0;
      default:   bit_out = 1'b0;
    endcase
    return bit_out;
  endfunction

endpackage

// File: rtl/parity_rx_chk.sv
// Serial RX parity checker: accumulates data bits LSB first, then compares the received parity bit.
module parity_rx_chk
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       par_en,
  input  logic [1:0] par_mode,
  input  logic       rx_start,
  input  logic       rx_bit_valid,
  input  logic       rx_bit,
  output logic       par_chk_done,
  output logic       par_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  chk_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             acc;
  logic             cfg_en;
  par_mode_t        cfg_mode;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      cnt          <= '0;
      acc          <= 1'b0;
      cfg_en       <= 1'b0;
      cfg_mode     <= PAR_EVEN;
      par_chk_done <= 1'b0;
      par_err      <= 1'b0;
    end else begin
      par_chk_done <= 1'b0;
      // A start bit always restarts the frame, even if a bit strobe arrives in the same cycle.
      if (rx_start) begin
        cfg_en   <= par_en;
        cfg_mode <= par_mode_t'(par_mode);
        acc      <= 1'b0;
        cnt      <= '0;
        par_err  <= 1'b0;
        state    <= DATA;
      end else begin
        case (state)
          DATA: begin
            if (rx_bit_valid) begin
              acc <= acc ^ rx_bit;
              cnt <= cnt + CNT_W'(1);
              if (cnt == LAST_BIT) begin
                state <= cfg_en ? PAR : IDLE;
              end
            end
          end
          PAR: begin
            if (rx_bit_valid) begin
              par_err      <= (rx_bit != par_fn(cfg_mode, acc));
              par_chk_done <= 1'b1;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/parity_gen_chk.sv
// UART parity unit: registered TX parity generation plus the serial RX parity checker.
module parity_gen_chk
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  par_en,
  input  logic [1:0]            par_mode,
  input  logic                  tx_data_valid,
  input  logic                  tx_busy,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_par_bit,
  input  logic                  rx_start,
  input  logic                  rx_bit_valid,
  input  logic                  rx_bit,
  output logic                  par_chk_done,
  output logic                  par_err
);

  logic tx_par_p1;

  // Stage p1: parity of the captured TX word; holds while the serializer is busy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_par_p1 <= 1'b0;
    end else if (tx_data_valid && !tx_busy) begin
      tx_par_p1 <= par_fn(par_mode_t'(par_mode), ^tx_data);
    end
  end

  assign tx_par_bit = tx_par_p1;

  parity_rx_chk #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rx_chk (
    .CLK          (CLK),
    .RST          (RST),
    .par_en       (par_en),
    .par_mode     (par_mode),
    .rx_start     (rx_start),
    .rx_bit_valid (rx_bit_valid),
    .rx_bit       (rx_bit),
    .par_chk_done (par_chk_done),
    .par_err      (par_err)
  );

endmodule

// File: tb/tb_parity_gen_chk.sv
// Directed bench for parity_gen_chk at DATA_WIDTH 8, 5 and 16 sharing one stimulus bus.
module tb_parity_gen_chk;

  logic        CLK = 1'b0;
  logic        RST;
  logic        par_en;
  logic [1:0]  par_mode;
  logic        tx_data_valid;
  logic        tx_busy;
  logic [7:0]  tx_data8;
  logic [4:0]  tx_data5;
  logic [15:0] tx_data16;
  logic        rx_start;
  logic        rx_bit_valid;
  logic        rx_bit;

  logic tx_par8, tx_par5, tx_par16;
  logic done8, done5, done16;
  logic err8, err5, err16;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt8 = 0;
  int done_cnt5 = 0;
  int done_cnt16 = 0;
  int d0;

  always #5 CLK = ~CLK;

  parity_gen_chk #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .par_en(par_en), .par_mode(par_mode),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .tx_data(tx_data8),
    .tx_par_bit(tx_par8), .rx_start(rx_start), .rx_bit_valid(rx_bit_valid),
    .rx_bit(rx_bit), .par_chk_done(done8), .par_err(err8)
  );

  parity_gen_chk #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .par_en(par_en), .par_mode(par_mode),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .tx_data(tx_data5),
    .tx_par_bit(tx_par5), .rx_start(rx_start), .rx_bit_valid(rx_bit_valid),
    .rx_bit(rx_bit), .par_chk_done(done5), .par_err(err5)
  );

  parity_gen_chk #(.DATA_WIDTH(16)) dut16 (
    .CLK(CLK), .RST(RST), .par_en(par_en), .par_mode(par_mode),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .tx_data(tx_data16),
    .tx_par_bit(tx_par16), .rx_start(rx_start), .rx_bit_valid(rx_bit_valid),
    .rx_bit(rx_bit), .par_chk_done(done16), .par_err(err16)
  );

  always @(negedge CLK) begin
    if (done8)  done_cnt8++;
    if (done5)  done_cnt5++;
    if (done16) done_cnt16++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame();
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rx_bit       = b;
    rx_bit_valid = 1'b1;
    tick();
    rx_bit_valid = 1'b0;
    rx_bit       = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[i]);
  endtask

  task automatic tx_capture(input logic [1:0] mode, input logic [7:0] d, input logic busy);
    par_mode      = mode;
    tx_data8      = d;
    tx_busy       = busy;
    tx_data_valid = 1'b1;
    tick();
    tx_data_valid = 1'b0;
    tx_busy       = 1'b0;
  endtask

  initial begin
    RST = 1'b1; par_en = 1'b0; par_mode = 2'b00;
    tx_data_valid = 1'b0; tx_busy = 1'b0;
    tx_data8 = 8'h00; tx_data5 = 5'h00; tx_data16 = 16'h0000;
    rx_start = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0;
    tick();
    tick();
    check("rst_tx_par", tx_par8, 0);
    check("rst_done", done8, 0);
    check("rst_err", err8, 0);
    RST = 1'b0;
    tick();

    // T1: TX parity across widths and modes
    tx_data5  = 5'b00111;
    tx_data16 = 16'h0003;
    tx_capture(2'b00, 8'hA5, 1'b0);
    check("t1_even_a5", tx_par8, 0);
    check("t1_even_w5", tx_par5, 1);
    check("t1_even_w16", tx_par16, 0);
    tx_capture(2'b01, 8'hA5, 1'b0);
    check("t1_odd_a5", tx_par8, 1);
    tx_capture(2'b00, 8'h07, 1'b0);
    check("t1_even_07", tx_par8, 1);

    // T2: busy blocks capture; mark/space ignore data; no valid means hold
    tx_capture(2'b01, 8'h01, 1'b1);
    check("t2_busy_hold", tx_par8, 1);
    tx_capture(2'b11, 8'hFF, 1'b0);
    check("t2_space", tx_par8, 0);
    tx_capture(2'b10, 8'h00, 1'b0);
    check("t2_mark", tx_par8, 1);
    par_mode = 2'b11;
    tick();
    check("t2_novalid_hold", tx_par8, 1);

    // T3: RX frame, correct then wrong parity
    par_en = 1'b1; par_mode = 2'b00;
    start_frame();
    d0 = done_cnt8;
    send_word(16'h00A5, 8);
    check("t3_no_early_done", done_cnt8, d0);
    send_bit(1'b0);
    check("t3_done", done8, 1);
    check("t3_err_ok", err8, 0);
    tick();
    check("t3_done_one_cycle", done8, 0);
    check("t3_done_count", done_cnt8 - d0, 1);
    start_frame();
    send_word(16'h00A5, 8);
    send_bit(1'b1);
    check("t3_done_bad", done8, 1);
    check("t3_err_bad", err8, 1);
    tick();
    check("t3_err_held", err8, 1);

    // T4: config latched at rx_start; mid-frame changes ignored
    par_en = 1'b1; par_mode = 2'b01;
    start_frame();
    check("t4_err_cleared", err8, 0);
    par_mode = 2'b00; par_en = 1'b0;
    send_word(16'h0000, 8);
    send_bit(1'b1);
    check("t4_done", done8, 1);
    check("t4_err", err8, 0);

    // T5: parity disabled, no done pulse, trailing strobe ignored
    par_en = 1'b0; par_mode = 2'b00;
    start_frame();
    d0 = done_cnt8;
    send_word(16'h003C, 8);
    send_bit(1'b1);
    tick();
    check("t5_no_done", done_cnt8, d0);
    check("t5_err", err8, 0);

    // T6: restart mid-frame, simultaneous start and bit strobe discards the bit
    par_en = 1'b1; par_mode = 2'b00;
    start_frame();
    send_word(16'h000F, 4);
    rx_start = 1'b1; rx_bit_valid = 1'b1; rx_bit = 1'b1;
    tick();
    rx_start = 1'b0; rx_bit_valid = 1'b0; rx_bit = 1'b0;
    d0 = done_cnt8;
    send_word(16'h0007, 8);
    check("t6_no_early_done", done_cnt8, d0);
    send_bit(1'b1);
    check("t6_restart_done", done8, 1);
    check("t6_restart_err", err8, 0);

    // T6: reset mid-frame clears outputs and returns to IDLE
    tx_capture(2'b10, 8'h00, 1'b0);
    check("t6_tx_mark_pre", tx_par8, 1);
    start_frame();
    send_word(16'h0005, 3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_rst_tx", tx_par8, 0);
    check("t6_rst_done", done8, 0);
    check("t6_rst_err", err8, 0);
    d0 = done_cnt8;
    send_word(16'h001F, 6);
    tick();
    check("t6_rst_idle", done_cnt8, d0);

    // DATA_WIDTH=5: 5'b10110 even parity is 1
    par_en = 1'b1; par_mode = 2'b00;
    start_frame();
    d0 = done_cnt5;
    send_word(16'h0016, 5);
    check("w5_no_early_done", done_cnt5, d0);
    send_bit(1'b1);
    check("w5_done", done5, 1);
    check("w5_err", err5, 0);
    start_frame();
    send_word(16'h000F, 4);
    start_frame();
    send_word(16'h0016, 5);
    send_bit(1'b0);
    check("w5_restart_done", done5, 1);
    check("w5_restart_err", err5, 1);

    // DATA_WIDTH=16: 16'h8001 even parity is 0
    start_frame();
    d0 = done_cnt16;
    send_word(16'h8001, 16);
    check("w16_no_early_done", done_cnt16, d0);
    send_bit(1'b0);
    check("w16_done", done16, 1);
    check("w16_err", err16, 0);
    par_mode = 2'b01;
    start_frame();
    send_word(16'h8001, 16);
    send_bit(1'b0);
    check("w16_odd_done", done16, 1);
    check("w16_odd_err", err16, 1);
    start_frame();
    send_word(16'h0007, 3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("w16_rst_err", err16, 0);
    d0 = done_cnt16;
    send_word(16'hFFFF, 16);
    send_bit(1'b1);
    tick();
    check("w16_rst_idle", done_cnt16, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
